// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS32 HI/LO multiply/divide unit with MTHI/MTLO writes.
module muldiv_unit #(
  parameter int data_width = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [data_width-1:0] a,
  input  logic [data_width-1:0] b,
  input  logic                  hi_we,
  input  logic                  lo_we,
  input  logic [data_width-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [data_width-1:0] hi,
  output logic [data_width-1:0] lo
);
  localparam int W  = data_width;
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    mc_q, a_q, hi_q, lo_q;
  logic            div_q, neg_q, rneg_q, dbz_q, done_q;
  logic            sgn;
  logic [W-1:0]    a_mag, b_mag, quo, rem;
  logic [W:0]      sum, diff;
  logic [2*W-1:0]  prod;
  // acc_q doubles as {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    sgn   = ~op[0];
    a_mag = (sgn & a[W-1]) ? -a : a;
    b_mag = (sgn & b[W-1]) ? -b : b;
    sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mc_q} : '0);
    diff  = {acc_q[2*W-1:W], acc_q[W-1]} - {1'b0, mc_q};
    acc_d = div_q ? {(diff[W] ? {acc_q[2*W-2:W], acc_q[W-1]} : diff[W-1:0]), acc_q[W-2:0], ~diff[W]}
                  : {sum, acc_q[W-1:1]};
    prod  = neg_q ? -acc_q : acc_q;
    quo   = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem   = rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mc_q    <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            state_q <= CALC;
            cnt_q   <= '0;
            div_q   <= op[1];
            a_q     <= a;
            neg_q   <= sgn & (a[W-1] ^ b[W-1]);
            rneg_q  <= sgn & a[W-1];
            dbz_q   <= (b == '0);
            mc_q    <= op[1] ? b_mag : a_mag;
            acc_q   <= {{W{1'b0}}, (op[1] ? a_mag : b_mag)};
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(W - 1)) state_q <= FINISH;
        end
        FINISH: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
          if (!div_q) {hi_q, lo_q} <= prod;
          else if (dbz_q) {hi_q, lo_q} <= {a_q, {W{1'b1}}};
          else {hi_q, lo_q} <= {rem, quo};
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench; driver queues expected {hi,lo}, monitor checks on done.
module tb_muldiv_unit;
  logic        clock = 0, reset = 1, start = 0, hi_we = 0, lo_we = 0;
  logic [1:0]  op = 0;
  logic [31:0] a = 0, b = 0, wdata = 0, hi, lo;
  logic        busy, done;
  logic [63:0] q[$];
  int checks = 0, errors = 0;
  muldiv_unit #(.data_width(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clock = ~clock;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else check("result", {hi, lo}, q.pop_front());
    end
  end
  task automatic issue(logic [1:0] o, logic [31:0] x, logic [31:0] y);
    start = 1; op = o; a = x; b = y;
  endtask
  task automatic release_start();
    @(posedge clock); #1;
    start = 0; a = $urandom; b = $urandom;
  endtask
  task automatic wait_done(output int n, output int nb);
    n = 0; nb = 0;
    do begin
      @(negedge clock);
      n++;
      if (busy) nb++;
    end while (done !== 1'b1 && n < 60);
    if (done !== 1'b1) check("done_timeout", {63'd0, done}, 64'd1);
  endtask
  task automatic run(logic [1:0] o, logic [31:0] x, logic [31:0] y, logic [63:0] exp);
    int n, nb;
    @(negedge clock);
    q.push_back(exp);
    issue(o, x, y);
    release_start();
    wait_done(n, nb);
  endtask
  initial begin
    int n, nb, cnt;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    reset = 0;
    @(negedge clock);
    q.push_back(64'hFFFFFFFE_00000001);
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    release_start();
    wait_done(n, nb);
    check("latency", 64'(n), 64'd34);
    check("busy_cycles", 64'(nb), 64'd33);
    run(2'b00, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB);
    run(2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
    run(2'b10, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    run(2'b11, 32'd7, 32'd2, 64'h00000001_00000003);
    run(2'b11, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC);
    run(2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    run(2'b11, 32'd5, 32'd0, 64'h00000005_FFFFFFFF);
    run(2'b10, 32'hFFFFFFFB, 32'd0, 64'hFFFFFFFB_FFFFFFFF);
    run(2'b01, 32'h12345678, 32'h0000_0010, 64'h00000001_23456780);
    // ignored start and MTLO while busy
    @(negedge clock);
    q.push_back(64'h00000001_00000003);
    issue(2'b11, 32'd7, 32'd2);
    release_start();
    repeat (4) @(negedge clock);
    issue(2'b01, 32'd2, 32'd3);
    lo_we = 1; wdata = 32'h1234;
    @(posedge clock); #1;
    start = 0; lo_we = 0;
    wait_done(n, nb);
    // back-to-back start in the done cycle
    q.push_back(64'h00000001_7FFFFFFC);
    issue(2'b11, 32'hFFFFFFF9, 32'd2);
    release_start();
    check("b2b_busy", {63'd0, busy}, 64'd1);
    wait_done(n, nb);
    @(negedge clock);
    hi_we = 1; wdata = 32'hABCD;
    @(posedge clock); #1;
    hi_we = 0;
    check("mthi", {hi, lo}, 64'h0000ABCD_7FFFFFFC);
    // reset mid-divide
    @(negedge clock);
    issue(2'b11, 32'd100, 32'd7);
    release_start();
    repeat (10) @(negedge clock);
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_done", {63'd0, done}, 64'd0);
    check("mid_rst_hilo", {hi, lo}, 64'd0);
    cnt = 0;
    repeat (40) begin
      @(negedge clock);
      if (done === 1'b1) cnt++;
    end
    check("no_done_after_rst", 64'(cnt), 64'd0);
    run(2'b11, 32'd100, 32'd7, 64'h00000002_0000000E);
    repeat (3) @(negedge clock);
    check("sb_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative HI/LO multiply/divide unit for the MIPS32 datapath; sits directly downstream of the register file.
- Operands come from the register file read ports (d1 -> a, d2 -> b).
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and holds results in architectural HI/LO registers, which MFHI/MFLO read combinationally.
- Also services MTHI/MTLO writes.

Parameters:
- data_width, 32, operand/HI/LO width; iteration count equals data_width.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when unit idle
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- a  input  data_width  rs operand (multiplicand / dividend)
- b  input  data_width  rt operand (multiplier / divisor)
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wdata  input  data_width  MTHI/MTLO data
- busy  output  1  operation in progress; pipeline stalls MF/MT/new op while high
- done  output  1  one-cycle pulse: HI/LO just updated by an operation
- hi  output  data_width  HI register
- lo  output  data_width  LO register

Behaviour:
- Reset (synchronous, rising edge with reset=1) has priority over everything:
  - state=IDLE; busy=0, done=0, hi=0, lo=0; internal counter/accumulators cleared.
  - Reset mid-operation discards the operation; no later done pulse.
- FSM states:
  - IDLE: start=1 at edge E0 latches op, a, b into internal regs and goes to CALC. Counter=0, busy=1 after E0.
  - CALC: one iteration per edge, 32 edges (E1..E32).
    - Multiply: radix-2 shift-add on 64-bit accumulator.
    - Divide: restoring shift-subtract on 32-bit remainder/quotient.
    - After the 32nd iteration, go to FINISH.
  - FINISH: at E33, sign fixup and write of hi/lo, then IDLE. done=1 for exactly the cycle after E33; busy=0 in that same cycle.
- busy = (state != IDLE). Start-to-done latency: done high 34 cycles after start is sampled.
- start while busy is ignored; no queueing.
- start is accepted in the done cycle (back-to-back operations).
- Signed ops (MULT, DIV):
  - Compute on magnitudes of a and b.
  - MULT product is negated when the operand signs differ.
  - DIV quotient is negated when signs differ, truncating toward zero.
  - DIV remainder takes the sign of the dividend.
- Result placement:
  - Multiply: hi = product[63:32], lo = product[31:0].
  - Divide: lo = quotient, hi = remainder.
- Divide by zero (DIV and DIVU): lo = all-ones, hi = a. No exception is raised.
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (no trap).
- MTHI/MTLO:
  - When idle, hi_we/lo_we write wdata into hi/lo at the edge. Both may be asserted together.
  - While busy they are ignored.
  - If asserted together with an accepted start, the write is applied; the operation result overwrites it at E33.
- hi/lo hold their value at all times except reset, MT write, or E33. They are not disturbed during CALC; intermediate state lives in private registers.
- Operands are latched at E0; a and b may change freely afterwards.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high 33 cycles; done pulse 34 cycles after start; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT a=0x80000000 b=0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=2 -> lo=3, hi=1. DIVU a=0xFFFFFFF9 b=2 -> lo=0x7FFFFFFC, hi=1.
- Boundary divides:
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
  - DIV 0xFFFFFFFB / 0 -> lo=0xFFFFFFFF, hi=0xFFFFFFFB.
- Handshake:
  - Second start (MULTU 2*3) at cycle 5 of a busy op is ignored; result is the first op's.
  - lo_we with wdata=0x1234 while busy is ignored.
  - start asserted in the done cycle is accepted (busy rises next cycle).
  - hi_we with wdata=0xABCD when idle -> hi=0xABCD next cycle, lo unchanged.
- Reset on the 10th CALC cycle of DIVU 100/7 -> next cycle busy=0, done=0, hi=lo=0; no done pulse within the following 40 cycles; a subsequent DIVU 100/7 gives lo=14, hi=2.
